// File: rtl/tetris_pkg.sv
// Shared types for the active-piece controller: move codes, piece orientation codes,
// sequencer FSM states and the 5x5 frame. SEQ_LOCK_DELAY_EN adds the LOCK_WAIT state.
package tetris_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    RIGHT = 3'd1,
    LEFT  = 3'd2,
    ROR   = 3'd3,
    ROL   = 3'd4,
    DOWN  = 3'd5
  } move_t;

  // Piece codes: bits [4:2] select the piece, bits [1:0] the orientation.
  typedef enum logic [4:0] {
    A1, A2, A3, A4,
    B1, B2, B3, B4,
    C1, C2, C3, C4,
    D1, D2, D3, D4,
    E1, E2, E3, E4,
    F1, F2, F3, F4,
    G1, G2, G3, G4
  } piece_state_t;

  typedef enum logic [2:0] {
    WAIT_SPAWN = 3'd0,
    IDLE       = 3'd1,
    ISSUE      = 3'd2,
    LOCK       = 3'd3
`ifdef SEQ_LOCK_DELAY_EN
    ,
    LOCK_WAIT  = 3'd4
`endif
  } seq_state_t;

  typedef logic [4:0][4:0][2:0] frame_t;

  // ROR steps the orientation forward, ROL backward, wrapping within the piece.
  function automatic logic [4:0] rotate_state(input logic [4:0] state, input move_t move);
    logic [1:0] ori;
    ori = state[1:0];
    case (move)
      ROR:     ori = ori + 2'd1;
      ROL:     ori = ori - 2'd1;
      default: ori = state[1:0];
    endcase
    return {state[4:2], ori};
  endfunction

endpackage

// File: rtl/move_sequencer.sv
// Owns the active-piece frame and sequences the external tracker one move at a time.
// Optional feature: SEQ_LOCK_DELAY_EN enables a LOCK_DELAY-cycle slide window before locking.
module move_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned LOCK_DELAY = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_ror,
  input  logic       req_rol,
  input  logic       gravity_tick,
  input  logic       spawn_valid,
  input  logic [4:0] spawn_state,
  input  logic [2:0] spawn_color,
  input  frame_t     spawn_frame,
  input  logic       trk_complete,
  input  frame_t     trk_frame,
  output logic [4:0] trk_state,
  output move_t      trk_move,
  output logic [2:0] trk_color,
  output frame_t     frame_q,
  output logic       busy,
  output logic       lock_pulse,
  output logic       reject_pulse,
  output seq_state_t dbg_state
);

  localparam int unsigned P_RIGHT = 0;
  localparam int unsigned P_LEFT  = 1;
  localparam int unsigned P_ROL   = 2;
  localparam int unsigned P_ROR   = 3;
  localparam int unsigned P_DOWN  = 4;

  if (LOCK_DELAY == 0) begin : g_bad_lock_delay
    $error("LOCK_DELAY must be at least 1");
  end

  seq_state_t fsm_q, fsm_d;
  frame_t     frame_d;
  logic [4:0] state_q, state_d;
  logic [2:0] color_q, color_d;
  logic [4:0] pend_q, pend_d, pend_clr, req_vec;
  logic       pend_flush, take_req;
  move_t      move_q, move_d;

`ifdef SEQ_LOCK_DELAY_EN
  localparam int unsigned CNT_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_wait_q, from_wait_d;
`endif

  function automatic move_t pick_move(input logic [4:0] p);
    if (p[P_DOWN])  return DOWN;
    if (p[P_ROR])   return ROR;
    if (p[P_ROL])   return ROL;
    if (p[P_LEFT])  return LEFT;
    if (p[P_RIGHT]) return RIGHT;
    return NONE;
  endfunction

  function automatic logic [4:0] move_mask(input move_t m);
    logic [4:0] mk;
    mk = '0;
    case (m)
      DOWN:    mk[P_DOWN]  = 1'b1;
      ROR:     mk[P_ROR]   = 1'b1;
      ROL:     mk[P_ROL]   = 1'b1;
      LEFT:    mk[P_LEFT]  = 1'b1;
      RIGHT:   mk[P_RIGHT] = 1'b1;
      default: mk = '0;
    endcase
    return mk;
  endfunction

  assign req_vec   = {gravity_tick, req_ror, req_rol, req_left, req_right};
  assign trk_state = state_q;
  assign trk_color = color_q;
  assign busy      = (fsm_q != IDLE);
  assign dbg_state = fsm_q;

  // Handshake: spawn_valid is a level qualifier with no ready; it is only sampled
  // in WAIT_SPAWN and a load happens in the first such cycle it is high.
  always_comb begin
    fsm_d        = fsm_q;
    frame_d      = frame_q;
    state_d      = state_q;
    color_d      = color_q;
    move_d       = move_q;
    pend_clr     = '0;
    pend_flush   = 1'b0;
    take_req     = 1'b1;
    trk_move     = NONE;
    lock_pulse   = 1'b0;
    reject_pulse = 1'b0;
`ifdef SEQ_LOCK_DELAY_EN
    cnt_d        = cnt_q;
    from_wait_d  = from_wait_q;
`endif
    case (fsm_q)
      WAIT_SPAWN: begin
        take_req = 1'b0;
        if (spawn_valid) begin
          frame_d    = spawn_frame;
          state_d    = spawn_state;
          color_d    = spawn_color;
          pend_flush = 1'b1;
          fsm_d      = IDLE;
        end
      end
      IDLE: begin
        if (|pend_q) begin
          move_d   = pick_move(pend_q);
          pend_clr = move_mask(move_d);
          fsm_d    = ISSUE;
`ifdef SEQ_LOCK_DELAY_EN
          from_wait_d = 1'b0;
`endif
        end
      end
      ISSUE: begin
        trk_move = move_q;
        if (trk_complete) begin
          frame_d = trk_frame;
          state_d = rotate_state(state_q, move_q);
          fsm_d   = IDLE;
`ifdef SEQ_LOCK_DELAY_EN
          from_wait_d = 1'b0;
`endif
        end else if (move_q == DOWN) begin
`ifdef SEQ_LOCK_DELAY_EN
          cnt_d = CNT_W'(LOCK_DELAY - 1);
          fsm_d = LOCK_WAIT;
`else
          fsm_d = LOCK;
`endif
        end else begin
          reject_pulse = 1'b1;
`ifdef SEQ_LOCK_DELAY_EN
          fsm_d = from_wait_q ? LOCK_WAIT : IDLE;
`else
          fsm_d = IDLE;
`endif
        end
      end
      LOCK: begin
        take_req   = 1'b0;
        lock_pulse = 1'b1;
        pend_flush = 1'b1;
        fsm_d      = WAIT_SPAWN;
      end
`ifdef SEQ_LOCK_DELAY_EN
      LOCK_WAIT: begin
        // A pending DOWN stays latched here; only slides and rotations can rescue the piece.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (|pend_q[P_ROR:P_RIGHT]) begin
          move_d      = pick_move({1'b0, pend_q[P_ROR:P_RIGHT]});
          pend_clr    = move_mask(move_d);
          from_wait_d = 1'b1;
          fsm_d       = ISSUE;
        end else if (cnt_q == '0) begin
          fsm_d = LOCK;
        end
      end
`endif
      default: fsm_d = WAIT_SPAWN;
    endcase
    // A request arriving in the cycle its bit is consumed wins over the clear.
    pend_d = pend_flush ? '0 : ((pend_q & ~pend_clr) | (take_req ? req_vec : 5'b0));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= WAIT_SPAWN;
      frame_q <= '0;
      state_q <= '0;
      color_q <= '0;
      pend_q  <= '0;
      move_q  <= NONE;
    end else begin
      fsm_q   <= fsm_d;
      frame_q <= frame_d;
      state_q <= state_d;
      color_q <= color_d;
      pend_q  <= pend_d;
      move_q  <= move_d;
    end
  end

`ifdef SEQ_LOCK_DELAY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= '0;
      from_wait_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      from_wait_q <= from_wait_d;
    end
  end
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model. Covers both SEQ_LOCK_DELAY_EN builds.
module tb_move_sequencer;
  import tetris_pkg::*;

  localparam int unsigned LD = 4;
  localparam int M_WAIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_ISSUE = 2;
  localparam int M_LOCK  = 3;
  localparam int M_LWAIT = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       req_left = 1'b0, req_right = 1'b0, req_ror = 1'b0, req_rol = 1'b0;
  logic       gravity_tick = 1'b0, spawn_valid = 1'b0, trk_complete = 1'b0;
  logic [4:0] spawn_state = '0;
  logic [2:0] spawn_color = '0;
  frame_t     spawn_frame = '0, trk_frame = '0;
  logic [4:0] trk_state;
  move_t      trk_move;
  logic [2:0] trk_color;
  frame_t     frame_q;
  logic       busy, lock_pulse, reject_pulse;
  seq_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int         m_mode;
  bit         m_pend[5];   // index order = priority: DOWN, ROR, ROL, LEFT, RIGHT
  move_t      m_move;
  frame_t     m_frame;
  logic [4:0] m_piece;
  logic [2:0] m_color;
  int         m_timer;
  bit         m_from_wait;
  move_t      prio_order[5] = '{DOWN, ROR, ROL, LEFT, RIGHT};

  frame_t fixed_frame, f1, f2, saved;

  always #5 clk = ~clk;

  move_sequencer #(.LOCK_DELAY(LD)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_left(req_left), .req_right(req_right), .req_ror(req_ror), .req_rol(req_rol),
    .gravity_tick(gravity_tick), .spawn_valid(spawn_valid),
    .spawn_state(spawn_state), .spawn_color(spawn_color), .spawn_frame(spawn_frame),
    .trk_complete(trk_complete), .trk_frame(trk_frame),
    .trk_state(trk_state), .trk_move(trk_move), .trk_color(trk_color),
    .frame_q(frame_q), .busy(busy), .lock_pulse(lock_pulse), .reject_pulse(reject_pulse),
    .dbg_state(dbg_state)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t rand_frame();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[74:0];
  endfunction

  function automatic logic [4:0] model_rotate(input int st, input move_t mv);
    int piece, ori;
    piece = st / 4;
    ori   = st % 4;
    if (mv == ROR) ori = (ori + 1) % 4;
    else if (mv == ROL) ori = (ori + 3) % 4;
    return 5'(piece * 4 + ori);
  endfunction

  function automatic int first_pending(input int start);
    for (int i = start; i < 5; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic seq_state_t mode_to_state(input int m);
    case (m)
      M_IDLE:  return IDLE;
      M_ISSUE: return ISSUE;
      M_LOCK:  return LOCK;
`ifdef SEQ_LOCK_DELAY_EN
      M_LWAIT: return LOCK_WAIT;
`endif
      default: return WAIT_SPAWN;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_move = NONE;
    m_frame = '0;
    m_piece = '0;
    m_color = '0;
    m_timer = 0;
    m_from_wait = 1'b0;
  endtask

  task automatic model_step();
    bit req[5];
    bit accept;
    int pick;
    req = '{gravity_tick, req_ror, req_rol, req_left, req_right};
    accept = 1'b1;
    case (m_mode)
      M_WAIT: begin
        accept = 1'b0;
        if (spawn_valid) begin
          m_frame = spawn_frame;
          m_piece = spawn_state;
          m_color = spawn_color;
          foreach (m_pend[i]) m_pend[i] = 1'b0;
          m_mode = M_IDLE;
        end
      end
      M_IDLE: begin
        pick = first_pending(0);
        if (pick >= 0) begin
          m_move = prio_order[pick];
          m_pend[pick] = 1'b0;
          m_from_wait = 1'b0;
          m_mode = M_ISSUE;
        end
      end
      M_ISSUE: begin
        if (trk_complete) begin
          m_frame = trk_frame;
          m_piece = model_rotate(int'(m_piece), m_move);
          m_from_wait = 1'b0;
          m_mode = M_IDLE;
        end else if (m_move == DOWN) begin
`ifdef SEQ_LOCK_DELAY_EN
          m_timer = LD - 1;
          m_mode = M_LWAIT;
`else
          m_mode = M_LOCK;
`endif
        end else begin
          m_mode = m_from_wait ? M_LWAIT : M_IDLE;
        end
      end
      M_LOCK: begin
        accept = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_mode = M_WAIT;
      end
      default: begin
        pick = first_pending(1);
        if (pick >= 0) begin
          m_move = prio_order[pick];
          m_pend[pick] = 1'b0;
          m_from_wait = 1'b1;
          m_mode = M_ISSUE;
        end else if (m_timer == 0) begin
          m_mode = M_LOCK;
        end
        if (m_timer > 0) m_timer--;
      end
    endcase
    if (accept) for (int i = 0; i < 5; i++) if (req[i]) m_pend[i] = 1'b1;
  endtask

  task automatic compare_outputs();
    move_t exp_move;
    exp_move = (m_mode == M_ISSUE) ? m_move : NONE;
    check_val("busy", 128'(busy), 128'(m_mode != M_IDLE));
    check_val("trk_move", 128'(trk_move), 128'(exp_move));
    check_val("lock_pulse", 128'(lock_pulse), 128'(m_mode == M_LOCK));
    check_val("reject_pulse", 128'(reject_pulse),
              128'(m_mode == M_ISSUE && !trk_complete && m_move != DOWN));
    check_val("trk_state", 128'(trk_state), 128'(m_piece));
    check_val("trk_color", 128'(trk_color), 128'(m_color));
    check_val("frame_q", 128'(frame_q), 128'(m_frame));
    check_val("dbg_state", 128'(dbg_state), 128'(mode_to_state(m_mode)));
    check_val("pulse_excl", 128'(lock_pulse & reject_pulse), 128'(0));
  endtask

  // Entered and left at posedge+1 with inputs for this cycle already driven.
  task automatic apply_cycle();
    #1;
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
    req_left = 1'b0; req_right = 1'b0; req_ror = 1'b0; req_rol = 1'b0;
    gravity_tick = 1'b0; spawn_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check_val("rst_busy", 128'(busy), 128'(1));
    check_val("rst_lock", 128'(lock_pulse), 128'(0));
    check_val("rst_reject", 128'(reject_pulse), 128'(0));
    check_val("rst_move", 128'(trk_move), 128'(NONE));
    check_val("rst_frame", 128'(frame_q), 128'(0));
    check_val("rst_state", 128'(trk_state), 128'(0));
    check_val("rst_color", 128'(trk_color), 128'(0));
    check_val("rst_fsm", 128'(dbg_state), 128'(WAIT_SPAWN));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic spawn(input logic [4:0] st, input logic [2:0] col, input frame_t fr);
    spawn_valid = 1'b1; spawn_state = st; spawn_color = col; spawn_frame = fr;
    apply_cycle();
  endtask

  initial begin
    model_reset();
    fixed_frame = rand_frame();
    f1 = rand_frame();
    f2 = rand_frame();
    @(posedge clk);
    #1;
    do_reset();

    // Spawn
    spawn(A1, 3'd5, fixed_frame);
    check_val("spawn_frame", 128'(frame_q), 128'(fixed_frame));
    check_val("spawn_busy", 128'(busy), 128'(0));
    check_val("spawn_state", 128'(trk_state), 128'(A1));
    check_val("spawn_color", 128'(trk_color), 128'(3'd5));

    // LEFT and RIGHT together, tracker accepting: LEFT first, RIGHT two cycles later
    req_left = 1'b1; req_right = 1'b1; trk_complete = 1'b1;
    apply_cycle();                       // N
    apply_cycle();                       // N+1
    check_val("lr_first", 128'(trk_move), 128'(LEFT));
    trk_frame = f1;
    apply_cycle();                       // N+2
    check_val("lr_frame1", 128'(frame_q), 128'(f1));
    apply_cycle();                       // N+3
    check_val("lr_second", 128'(trk_move), 128'(RIGHT));
    trk_frame = f2;
    apply_cycle();                       // N+4
    check_val("lr_frame2", 128'(frame_q), 128'(f2));

    // Refused ROR
    saved = frame_q;
    req_ror = 1'b1; trk_complete = 1'b0; trk_frame = rand_frame();
    apply_cycle();
    apply_cycle();
    #1;
    check_val("ror_reject", 128'(reject_pulse), 128'(1));
    apply_cycle();
    check_val("ror_one_cycle", 128'(reject_pulse), 128'(0));
    check_val("ror_frame_kept", 128'(frame_q), 128'(saved));
    check_val("ror_state_kept", 128'(trk_state), 128'(A1));

    // Accepted ROL wraps A1 -> A4
    req_rol = 1'b1; trk_complete = 1'b1;
    apply_cycle();
    apply_cycle();
    apply_cycle();
    check_val("rol_wrap", 128'(trk_state), 128'(A4));

    // Failed DOWN
    gravity_tick = 1'b1; trk_complete = 1'b0;
    apply_cycle();
    apply_cycle();
    check_val("down_issue", 128'(trk_move), 128'(DOWN));
    apply_cycle();
`ifdef SEQ_LOCK_DELAY_EN
    for (int i = 0; i < LD; i++) begin
      check_val("lw_state", 128'(dbg_state), 128'(LOCK_WAIT));
      check_val("lw_no_lock", 128'(lock_pulse), 128'(0));
      apply_cycle();
    end
    check_val("lw_lock", 128'(lock_pulse), 128'(1));
    apply_cycle();
    spawn(B1, 3'd2, rand_frame());
    // Failed DOWN rescued by a LEFT in LOCK_WAIT
    gravity_tick = 1'b1; trk_complete = 1'b0;
    apply_cycle();
    apply_cycle();
    apply_cycle();
    req_left = 1'b1; trk_complete = 1'b1;
    apply_cycle();
    apply_cycle();
    check_val("lw_left_issue", 128'(trk_move), 128'(LEFT));
    apply_cycle();
    check_val("lw_rescued", 128'(dbg_state), 128'(IDLE));
    for (int i = 0; i < 6; i++) apply_cycle();
`else
    check_val("lock_now", 128'(lock_pulse), 128'(1));
    req_left = 1'b1;
    apply_cycle();
    check_val("after_lock", 128'(dbg_state), 128'(WAIT_SPAWN));
    req_right = 1'b1;
    apply_cycle();
    trk_complete = 1'b1;
    spawn(B1, 3'd2, rand_frame());
    check_val("drop_busy0", 128'(busy), 128'(0));
    apply_cycle();
    check_val("drop_busy1", 128'(busy), 128'(0));
`endif

    // Reset during ISSUE
    req_left = 1'b1; trk_complete = 1'b1;
    apply_cycle();
    apply_cycle();
    check_val("pre_rst_issue", 128'(dbg_state), 128'(ISSUE));
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req_left     = ($urandom_range(0, 7) == 0);
      req_right    = ($urandom_range(0, 7) == 0);
      req_ror      = ($urandom_range(0, 9) == 0);
      req_rol      = ($urandom_range(0, 9) == 0);
      gravity_tick = ($urandom_range(0, 11) == 0);
      spawn_valid  = ($urandom_range(0, 2) == 0);
      spawn_state  = 5'($urandom_range(0, 31));
      spawn_color  = 3'($urandom());
      spawn_frame  = rand_frame();
      trk_complete = ($urandom_range(0, 3) != 0);
      trk_frame    = rand_frame();
      if ($urandom_range(0, 399) == 0) do_reset();
      else apply_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
